// File: rtl/cp0_defs.sv
// Shared CP0 definitions for the exception unit and its timer.
//   - CP0 register addresses implemented by this block
//   - bit positions of the MEM-stage excptype flags
//   - ExcCode values written to Cause[6:2]
//   - writable-field masks and the default handler vector
package cp0_defs;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   localparam int unsigned EXC_SYSCALL_BIT = 8;
   localparam int unsigned EXC_RI_BIT      = 9;
   localparam int unsigned EXC_OV_BIT      = 10;
   localparam int unsigned EXC_ERET_BIT    = 12;

   typedef enum logic [4:0] {
      EXC_INT = 5'd0,
      EXC_SYS = 5'd8,
      EXC_RI  = 5'd10,
      EXC_OV  = 5'd12
   } exc_code_e;

   // Status: IM[15:8], EXL[1], IE[0]
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0040;

   function automatic logic is_impl(input logic [4:0] addr);
      return (addr == REG_COUNT) || (addr == REG_COMPARE) || (addr == REG_STATUS) ||
             (addr == REG_CAUSE) || (addr == REG_EPC);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
//   clk, rst      : clock, synchronous active-high reset
//   count_we      : mtc0 write to Count (overrides the increment)
//   compare_we    : mtc0 write to Compare (clears timer_int)
//   wdata         : mtc0 write data
//   count/compare : current register values
//   timer_int     : sticky Count==Compare match (Compare != 0)
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_int
);

   logic match;

   assign match = (count == compare) && (compare != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         compare   <= '0;
         timer_int <= 1'b0;
      end else begin
         if (count_we) count <= wdata;
         else          count <= count + 32'd1;

         if (compare_we) compare <= wdata;

         // Compare write acknowledges the interrupt and beats a same-cycle match
         if (compare_we) timer_int <= 1'b0;
         else if (match) timer_int <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_excpt_unit.sv
// CP0 register file with exception/interrupt arbiter.
//   clk, rst        : clock, synchronous active-high reset
//   we/waddr/wdata  : mtc0 write port (MEM)
//   raddr/rdata     : mfc0 read port (EX), combinational with write bypass
//   excptype/pc_mem : MEM-stage exception flags and PC
//   inst_valid      : MEM holds a real instruction
//   hw_int          : level-sensitive external interrupts -> Cause.IP[15:10]
//   excpt/ejpc      : one-cycle redirect pulse and target
//   status/cause    : current Status and Cause
//   timer_int       : timer interrupt pending
module cp0_excpt_unit
   import cp0_defs::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
   parameter int unsigned TIMER_IP   = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   input  logic [31:0] excptype,
   input  logic [31:0] pc_mem,
   input  logic        inst_valid,
   input  logic [5:0]  hw_int,
   output logic        excpt,
   output logic [31:0] ejpc,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic        timer_int
);

   logic [31:0] count, compare, epc;
   logic        int_req, take, eret;
   exc_code_e   code;
   logic [7:0]  ip_next;
   logic        unused_excptype;

   assign unused_excptype = ^{excptype[31:13], excptype[11], excptype[7:0]};

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (we && (waddr == REG_COUNT)),
      .compare_we (we && (waddr == REG_COMPARE)),
      .wdata      (wdata),
      .count      (count),
      .compare    (compare),
      .timer_int  (timer_int)
   );

   assign int_req = status[0] & ~status[1] & (|(status[15:8] & cause[15:8])) & inst_valid;

   // Detection is blocked during the redirect cycle: MEM is being flushed
   always_comb begin
      take = 1'b0;
      eret = 1'b0;
      code = EXC_INT;
      if (!excpt) begin
         if (int_req) begin
            take = 1'b1;
            code = EXC_INT;
         end else if (excptype[EXC_SYSCALL_BIT]) begin
            take = 1'b1;
            code = EXC_SYS;
         end else if (excptype[EXC_RI_BIT]) begin
            take = 1'b1;
            code = EXC_RI;
         end else if (excptype[EXC_OV_BIT]) begin
            take = 1'b1;
            code = EXC_OV;
         end else if (excptype[EXC_ERET_BIT]) begin
            eret = 1'b1;
         end
      end
   end

   // IP[1:0] are software-writable, IP[7:2] follow hw_int, timer ORs into its bit
   always_comb begin
      ip_next = cause[15:8];
      if (we && (waddr == REG_CAUSE)) ip_next[1:0] = wdata[9:8];
      ip_next[7:2] = hw_int;
      ip_next[TIMER_IP] = ip_next[TIMER_IP] | timer_int;
   end

   // mtc0 writes first; hardware updates below override only the fields they own
   always_ff @(posedge clk) begin
      if (rst) begin
         status <= '0;
         cause  <= '0;
         epc    <= '0;
         excpt  <= 1'b0;
         ejpc   <= '0;
      end else begin
         if (we && (waddr == REG_STATUS)) status <= wdata & STATUS_WMASK;
         if (we && (waddr == REG_EPC))    epc    <= wdata;
         cause[15:8] <= ip_next;

         if (take) begin
            epc        <= pc_mem;
            cause[6:2] <= code;
            status[1]  <= 1'b1;
            excpt      <= 1'b1;
            ejpc       <= EXC_VECTOR;
         end else if (eret) begin
            status[1]  <= 1'b0;
            excpt      <= 1'b1;
            ejpc       <= epc;
         end else begin
            excpt      <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (raddr)
         REG_COUNT:   rdata = count;
         REG_COMPARE: rdata = compare;
         REG_STATUS:  rdata = status;
         REG_CAUSE:   rdata = cause;
         REG_EPC:     rdata = epc;
         default:     rdata = '0;
      endcase
      if (we && (waddr == raddr) && is_impl(raddr)) rdata = wdata;
   end

endmodule
